node_row_scan_ctrl: RTL and testbench
=====================================

Name: node_row_scan_ctrl

Overview:
- Scheduler for a ROWS x COLS array of comparison nodes.
- Each node needs its enable ("high") held for a fixed WINDOW of clocks while it sequences its neighbour inputs, then presents a 1-bit flag.
- This block enables one row at a time, holds the enable long enough for the row's flags to be valid, and captures them into a hit bitmap with a running popcount.
- It signals done when the whole array has been scanned; a host pulses start and reads the results.

Parameters:
- ROWS, 4: number of node rows; one enable line per row.
- COLS, 4: nodes per row; width of the row flag bus.
- WINDOW, 4: clocks per row evaluation (the node neighbour-slot count). Legal range is 2..15.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a scan. Honoured only in IDLE.
- abort  input  1  terminates an active scan.
- row_en  output  ROWS  one-hot (or zero) enable to the node rows, driven to the nodes' high inputs.
- row_out  input  COLS  flag outputs of the currently enabled row.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a scan completes normally.
- aborted  output  1  one-cycle pulse when a scan is terminated by abort.
- cur_row  output  clog2(ROWS)  index of the row being scanned; 0 in IDLE.
- hit_map  output  ROWS*COLS  captured flags; bit r*COLS+c = node (r,c).
- hit_count  output  clog2(ROWS*COLS+1)  number of set bits in hit_map.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE.
  - row_en, busy, done, aborted, cur_row, hit_map, hit_count all 0.
  - Reset wins over every other input, including mid-scan; row_en is low the cycle after.
- All outputs are registered.
- States are IDLE, RUN, HOLD, GAP, DONE.
- IDLE:
  - On start=1 and abort=0: clear hit_map and hit_count, cur_row=0, slot=0, go to RUN.
  - If start and abort are both high, abort wins and the block stays in IDLE with no pulse.
- RUN:
  - row_en = 1<<cur_row.
  - slot counts 0..WINDOW-1, one per clock.
  - At slot==WINDOW-1 go to HOLD.
- HOLD (1 cycle):
  - row_en stays asserted.
  - At the end of the cycle, capture row_out into hit_map[cur_row*COLS +: COLS].
  - Add popcount(row_out) to hit_count.
  - If cur_row==ROWS-1 go to DONE, else go to GAP.
- GAP (1 cycle):
  - row_en=0 so the nodes reset their internal slot counters.
  - cur_row increments, slot=0, go to RUN.
- DONE (1 cycle):
  - done=1, row_en=0, busy=1.
  - Then go to IDLE; cur_row returns to 0.
- Timing:
  - Per row: WINDOW + 2 cycles (RUN + HOLD + GAP).
  - With start sampled at edge 0, done is high during cycle ROWS*(WINDOW+2).
  - For the defaults that is cycle 24.
- abort in RUN, HOLD or GAP:
  - Next state is IDLE, row_en=0, aborted pulses for 1 cycle, done does not pulse.
  - hit_map and hit_count keep the rows fully captured before the abort.
  - A HOLD capture coinciding with abort is discarded.
- abort in DONE is ignored; done still pulses.
- start while busy is ignored and does not restart the scan.
- row_en must never have more than one bit set.
- row_out is ignored outside HOLD.
- hit_map and hit_count are stable in IDLE until the next accepted start.
- hit_count cannot overflow: its width covers ROWS*COLS.

Test Plan:
- Defaults, start pulse, row_out=4'b0101 for every row:
  - row_en sequence 0001(x5), 0000, 0010(x5), 0000, 0100(x5), 0000, 1000(x5).
  - done at cycle 24, hit_map=16'h5555, hit_count=8, busy low from cycle 25.
- row_out driven per row as 4'b0001, 4'b0000, 4'b1111, 4'b1000, valid only in HOLD and garbage elsewhere:
  - hit_map=16'h8F01, hit_count=6.
- abort asserted in row 2's RUN (cycle 14):
  - row_en=0 next cycle, aborted pulses, no done.
  - hit_map keeps rows 0-1 only, hit_count matches.
- start re-pulsed at cycles 3 and 10 mid-scan:
  - Ignored; done still at cycle 24.
  - A second scan started after done clears hit_map first.
- rst low at cycle 9 mid-scan:
  - Next cycle all outputs 0 and state IDLE.
  - A new start completes normally in 24 cycles.
- start and abort high together in IDLE:
  - No state change, no pulses.
- Separately, WINDOW=2, ROWS=2:
  - done at cycle 8.

Source files
------------

// File: rtl/node_row_scan_ctrl.sv
// Row-at-a-time scheduler for a ROWS x COLS node array: holds each row's enable
// for WINDOW clocks, captures the row flags into a bitmap and keeps a running popcount.
module node_row_scan_ctrl #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int WINDOW = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  output logic [ROWS-1:0]                  row_en,
  input  logic [COLS-1:0]                  row_out,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted,
  output logic [$clog2(ROWS)-1:0]          cur_row,
  output logic [ROWS*COLS-1:0]             hit_map,
  output logic [$clog2(ROWS*COLS+1)-1:0]   hit_count
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS*COLS+1);
  localparam int SW = 4;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_HOLD, S_GAP, S_DONE} state_t;

  state_t          state_reg;
  logic [SW-1:0]   slot_reg;
  logic [CW-1:0]   row_pop;
  logic            scan_start;
  logic            row_capture;
  logic            scan_active;

  assign scan_start  = (state_reg == S_IDLE) && start && !abort;
  assign row_capture = (state_reg == S_HOLD) && !abort;
  assign scan_active = (state_reg == S_RUN) || (state_reg == S_HOLD) || (state_reg == S_GAP);

  always_comb begin
    row_pop = '0;
    for (int i = 0; i < COLS; i++) begin
      row_pop = row_pop + CW'(row_out[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      slot_reg  <= '0;
      row_en    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cur_row   <= '0;
      hit_count <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (scan_active && abort) begin
        // A capture coinciding with abort is dropped: hit_count is left untouched.
        state_reg <= S_IDLE;
        row_en    <= '0;
        busy      <= 1'b0;
        aborted   <= 1'b1;
        cur_row   <= '0;
        slot_reg  <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (scan_start) begin
              state_reg <= S_RUN;
              hit_count <= '0;
              cur_row   <= '0;
              slot_reg  <= '0;
              row_en    <= ROWS'(1);
              busy      <= 1'b1;
            end
          end
          S_RUN: begin
            if (slot_reg == SW'(WINDOW-1)) begin
              state_reg <= S_HOLD;
            end else begin
              slot_reg <= slot_reg + 1'b1;
            end
          end
          S_HOLD: begin
            hit_count <= hit_count + row_pop;
            row_en    <= '0;
            if (cur_row == RW'(ROWS-1)) begin
              state_reg <= S_DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= S_GAP;
            end
          end
          S_GAP: begin
            state_reg <= S_RUN;
            slot_reg  <= '0;
            cur_row   <= cur_row + 1'b1;
            row_en    <= ROWS'(1) << (cur_row + 1'b1);
          end
          S_DONE: begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            cur_row   <= '0;
          end
          default: begin
            state_reg <= S_IDLE;
            row_en    <= '0;
            busy      <= 1'b0;
            cur_row   <= '0;
          end
        endcase
      end
    end
  end

  // One flag register per row, loaded only from that row's HOLD cycle.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [COLS-1:0] flags_reg;
      always_ff @(posedge clk) begin
        if (!rst || scan_start) begin
          flags_reg <= '0;
        end else if (row_capture && (cur_row == RW'(gi))) begin
          flags_reg <= row_out;
        end
      end
      assign hit_map[gi*COLS +: COLS] = flags_reg;
    end
  endgenerate
endmodule

// File: tb/tb_node_row_scan_ctrl.sv
// Randomized bench for node_row_scan_ctrl: a cycle-schedule model predicts every
// output per cycle; a second small instance covers WINDOW=2, ROWS=2.
module tb_node_row_scan_ctrl;
  localparam int R = 4;
  localparam int C = 4;
  localparam int W = 4;
  localparam int P = W + 2;
  localparam int N = R * P;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [R-1:0]   row_en;
  logic [C-1:0]   row_out = '0;
  logic           busy, done, aborted;
  logic [1:0]     cur_row;
  logic [R*C-1:0] hit_map;
  logic [4:0]     hit_count;

  logic           start_s = 1'b0;
  logic           abort_s = 1'b0;
  logic [1:0]     row_en_s;
  logic [3:0]     row_out_s = 4'b0011;
  logic           busy_s, done_s, aborted_s;
  logic [0:0]     cur_row_s;
  logic [7:0]     hit_map_s;
  logic [3:0]     hit_count_s;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  node_row_scan_ctrl #(.ROWS(R), .COLS(C), .WINDOW(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .row_en(row_en),
    .row_out(row_out), .busy(busy), .done(done), .aborted(aborted),
    .cur_row(cur_row), .hit_map(hit_map), .hit_count(hit_count)
  );

  node_row_scan_ctrl #(.ROWS(2), .COLS(4), .WINDOW(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .row_en(row_en_s),
    .row_out(row_out_s), .busy(busy_s), .done(done_s), .aborted(aborted_s),
    .cur_row(cur_row_s), .hit_map(hit_map_s), .hit_count(hit_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Runs one scan from IDLE. Cycle t means the outputs seen after t edges, counting the
  // start-sampling edge as the first. abort_t / rst_t select the cycle during which
  // abort / rst(=0) is held; mode picks the per-row flag pattern.
  task automatic run_scan(input int abort_t, input int rst_t, input bit repulse,
                          input int mode, input bit abort_in_done,
                          output logic [R*C-1:0] map_out);
    logic [C-1:0]   tbl [R];
    logic [C-1:0]   pat [R];
    logic [R*C-1:0] exp_map;
    logic [R-1:0]   exp_en;
    logic           exp_busy, exp_done, exp_ab;
    int             exp_cur, row, ph, stop_t, kind;
    tbl[0] = 4'b0001; tbl[1] = 4'b0000; tbl[2] = 4'b1111; tbl[3] = 4'b1000;
    for (int r = 0; r < R; r++) begin
      pat[r] = (mode == 0) ? 4'b0101 : (mode == 1) ? tbl[r] : C'($urandom);
    end
    exp_map = '0;
    stop_t  = 1000;
    kind    = 0;
    start   = 1'b1;
    abort   = 1'b0;
    rst     = 1'b1;
    row_out = C'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= N + 3 && t <= stop_t + 3; t++) begin
      row = (t - 1) / P;
      ph  = (t - 1) % P;
      if (t > stop_t) begin
        exp_en = '0; exp_busy = 0; exp_done = 0; exp_cur = 0;
        exp_ab = (kind == 1) && (t == stop_t + 1);
      end else if (t < N) begin
        exp_en = (ph <= W) ? R'(1) << row : '0;
        exp_busy = 1; exp_done = 0; exp_cur = row; exp_ab = 0;
      end else begin
        exp_en = '0; exp_busy = 1; exp_done = 1; exp_cur = R - 1; exp_ab = 0;
      end
      chk("row_en", 32'(row_en), 32'(exp_en));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("aborted", 32'(aborted), 32'(exp_ab));
      chk("cur_row", 32'(cur_row), 32'(exp_cur));
      chk("hit_map", 32'(hit_map), 32'(exp_map));
      chk("hit_count", 32'(hit_count), 32'($countones(exp_map)));
      // Inputs for the edge that ends cycle t; row_out is garbage except in HOLD.
      row_out = C'($urandom);
      abort   = (t == abort_t) || (abort_in_done && t == N);
      rst     = (t != rst_t);
      start   = repulse && (t == 3 || t == 10);
      if (t <= stop_t && t < N && ph == W) row_out = pat[row];
      if (t <= stop_t) begin
        if (t == rst_t) begin
          stop_t = t; kind = 2; exp_map = '0;
        end else if (t < N && abort) begin
          stop_t = t; kind = 1;
        end else if (t < N && ph == W) begin
          exp_map[row*C +: C] = pat[row];
        end else if (t == N) begin
          stop_t = t; kind = 0;
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; abort = 1'b0; start = 1'b0;
    map_out = exp_map;
  endtask

  initial begin
    logic [R*C-1:0] m;
    logic [R*C-1:0] held;
    int cyc;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_row_en", 32'(row_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_aborted", 32'(aborted), 0);
    chk("rst_cur_row", 32'(cur_row), 0);
    chk("rst_hit_map", 32'(hit_map), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_s_busy", 32'(busy_s), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_scan(0, 0, 0, 0, 0, m);
    chk("plan_map_5555", 32'(hit_map), 32'h5555);
    chk("plan_count_8", 32'(hit_count), 8);
    $display("scan all-0101: hit_map=%h hit_count=%0d", hit_map, hit_count);

    run_scan(0, 0, 0, 1, 0, m);
    chk("plan_map_8f01", 32'(hit_map), 32'h8F01);
    chk("plan_count_6", 32'(hit_count), 6);
    $display("scan per-row: hit_map=%h hit_count=%0d", hit_map, hit_count);

    run_scan(14, 0, 0, 1, 0, m);
    chk("abort_map_rows01", 32'(hit_map), 32'h0001);
    $display("scan abort@14: hit_map=%h hit_count=%0d", hit_map, hit_count);

    run_scan(11, 0, 0, 2, 0, m);
    $display("scan abort@hold11: hit_map=%h hit_count=%0d", hit_map, hit_count);

    run_scan(0, 0, 1, 0, 1, m);
    $display("scan restart-ignored+abort-in-done: hit_map=%h", hit_map);
    run_scan(0, 0, 0, 1, 0, m);
    $display("second scan after done: hit_map=%h", hit_map);

    run_scan(0, 9, 0, 2, 0, m);
    $display("scan rst@9: hit_map=%h busy=%0b", hit_map, busy);
    run_scan(0, 0, 0, 0, 0, m);
    $display("scan after reset: hit_map=%h hit_count=%0d", hit_map, hit_count);

    held = hit_map;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("sa_busy", 32'(busy), 0);
      chk("sa_row_en", 32'(row_en), 0);
      chk("sa_aborted", 32'(aborted), 0);
      chk("sa_done", 32'(done), 0);
      chk("sa_hit_map", 32'(hit_map), 32'(held));
      @(posedge clk); #1;
    end
    $display("start+abort in idle: busy=%0b hit_map=%h", busy, hit_map);

    for (int s = 0; s < 6; s++) begin
      run_scan(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N - 1)) : 0, 0, 0, 2, 0, m);
      $display("random scan %0d: hit_map=%h hit_count=%0d", s, hit_map, hit_count);
    end

    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    cyc = 1;
    while (!done_s && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("small_done_cycle", 32'(cyc), 8);
    chk("small_hit_map", 32'(hit_map_s), 32'h33);
    chk("small_hit_count", 32'(hit_count_s), 4);
    @(posedge clk); #1;
    chk("small_idle_busy", 32'(busy_s), 0);
    $display("small scan: done at cycle %0d hit_map=%h", cyc, hit_map_s);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
